imem_loader: RTL and testbench

Boot-time loader that receives a program image as a byte stream and writes it, one 32-bit word at a time, into the writable instruction RAM's write port. The CPU fetch path reads the same RAM by word index `pc[6:2]`. The loader holds the CPU in reset (`cpu_hold`) until a complete image with a valid checksum has been written. It sits between the host byte link (UART receiver or debug port) and the instruction RAM.

---
 rtl/imem_pkg.sv | 12 +
 rtl/imem_word_packer.sv | 29 ++
 rtl/imem_loader.sv | 99 +++++++++
 tb/tb_imem_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-RAM boot loader.
package imem_pkg;
    localparam int DEPTH_LOG2_DEF = 5;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_CHECK = 2'd2;
    localparam state_t ST_FIN   = 2'd3;
endpackage

// File: rtl/imem_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream; word_valid fires with the 4th byte.
module imem_word_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              strobe,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);
    logic [23:0] shreg;
    logic [1:0]  byte_idx;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shreg    <= '0;
            byte_idx <= '0;
        end else if (strobe) begin
            shreg    <= {shreg[15:0], byte_in};
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // The 4th byte is still on the bus, so the word is completed combinationally.
    assign word_valid = strobe && (byte_idx == 2'd3);
    assign word       = {shreg, byte_in};
endmodule

// File: rtl/imem_loader.sv
// Boot loader: header / 4*N data bytes / XOR checksum, written word-wise into instruction RAM.
//   state    | meaning
//   IDLE     | waiting for a header byte
//   LOAD     | collecting data bytes, one RAM write per 4 bytes
//   CHECK    | waiting for the checksum byte
//   FIN      | done pulse; release cpu_hold when the checksum matched
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_W-1:0]     rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  we,
    output logic [DEPTH_LOG2-1:0] waddr,
    output logic [WORD_W-1:0]     wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);
    state_t                state;
    logic [DEPTH_LOG2-1:0] cnt_m1;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [BYTE_W-1:0]     csum;
    logic                  xfer;
    logic                  word_valid;
    logic [WORD_W-1:0]     word;

    assign rx_ready = (state != ST_FIN);
    assign xfer     = rx_valid && rx_ready;

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (xfer && (state == ST_IDLE)),
        .byte_in    (rx_data),
        .strobe     (xfer && (state == ST_LOAD)),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt_m1   <= '0;
            word_idx <= '0;
            csum     <= '0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            done     <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        cnt_m1   <= rx_data[DEPTH_LOG2-1:0];
                        word_idx <= '0;
                        csum     <= '0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        csum <= csum ^ rx_data;
                        if (word_valid) begin
                            we    <= 1'b1;
                            waddr <= word_idx;
                            wdata <= word;
                            // Stop at the last word rather than incrementing, so waddr never wraps.
                            if (word_idx == cnt_m1) state <= ST_CHECK;
                            else                    word_idx <= word_idx + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (xfer) begin
                        err   <= (rx_data != csum);
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    if (!err) cpu_hold <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized frames against a byte-level model.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, we, cpu_hold, done, err;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    imem_loader #(.DEPTH_LOG2(5)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int frames  = 0;
    int mon_done = 0;

    logic [4:0]  mon_addr[$];
    logic [31:0] mon_data[$];
    int          mon_cyc[$];
    logic [4:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_cyc[$];
    logic [7:0]  tx_q[$];

    always @(negedge clk) begin
        if (we) begin
            mon_addr.push_back(waddr);
            mon_data.push_back(wdata);
            mon_cyc.push_back(cyc);
        end
        if (done) mon_done++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_ready", 32'(rx_ready), 1);
        check("rst_we",    32'(we), 0);
        check("rst_waddr", 32'(waddr), 0);
        check("rst_wdata", wdata, 0);
        check("rst_done",  32'(done), 0);
        check("rst_err",   32'(err), 0);
        check("rst_hold",  32'(cpu_hold), 1);
    endtask

    task automatic compare_writes();
        int n;
        check("n_writes", 32'(mon_addr.size()), 32'(exp_addr.size()));
        n = (mon_addr.size() < exp_addr.size()) ? mon_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check("waddr", 32'(mon_addr[i]), 32'(exp_addr[i]));
            check("wdata", mon_data[i], exp_data[i]);
            check("we_cycle", mon_cyc[i], exp_cyc[i]);
        end
        mon_addr.delete(); mon_data.delete(); mon_cyc.delete();
        exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
    endtask

    task automatic idle_cycle();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
        check("ready_in_gap", 32'(rx_ready), 1);
        @(posedge clk); #1;
    endtask

    task automatic gaps(input int mode);
        if (mode == 1) idle_cycle();
        else if (mode == 2) repeat ($urandom_range(0, 2)) idle_cycle();
    endtask

    // Drives one byte until accepted; returns the cycle of the transfer.
    task automatic send_byte(input logic [7:0] b, output int tc);
        bit got;
        got = 1'b0;
        tc = -1;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                got = 1'b1;
                tc  = cyc;
            end
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        check("xfer_accepted", 32'(got), 1);
    endtask

    task automatic send_frame(input logic [7:0] hdr, input int mode, input bit corrupt, input bit chk_timing);
        int n, tc, hc, ndone;
        logic [31:0] w;
        logic [7:0]  x, cs;
        n = int'(hdr[4:0]) + 1;
        if (tx_q.size() == 0)
            for (int i = 0; i < 4 * n; i++) tx_q.push_back(8'($urandom));
        x = 8'h00;
        w = 32'h0;
        ndone = mon_done;
        gaps(mode);
        send_byte(hdr, hc);
        check("hdr_err_clear", 32'(err), 0);
        check("hdr_hold", 32'(cpu_hold), 1);
        for (int i = 0; i < 4 * n; i++) begin
            gaps(mode);
            send_byte(tx_q[i], tc);
            w = {w[23:0], tx_q[i]};
            x = x ^ tx_q[i];
            if (i % 4 == 3) begin
                exp_addr.push_back(5'(i / 4));
                exp_data.push_back(w);
                exp_cyc.push_back(tc + 1);
            end
        end
        cs = corrupt ? (x ^ 8'h01) : x;
        gaps(mode);
        send_byte(cs, tc);
        if (chk_timing) check("csum_cycle", tc - hc, 5);
        check("done_pulse", 32'(done), 1);
        check("err_at_done", 32'(err), 32'(corrupt));
        check("ready_in_fin", 32'(rx_ready), 0);
        @(posedge clk); #1;
        check("done_single", 32'(done), 0);
        check("hold_after", 32'(cpu_hold), 32'(corrupt));
        check("err_hold", 32'(err), 32'(corrupt));
        check("done_count", mon_done - ndone, 1);
        compare_writes();
        tx_q.delete();
        frames++;
    endtask

    initial begin
        int tc;
        logic [31:0] w;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;
        @(posedge clk); #1;

        // Gap-free single word with exact cycle timing.
        tx_q = '{8'h20, 8'h01, 8'h00, 8'h08};
        send_frame(8'h00, 0, 1'b0, 1'b1);

        // Same frame, valid toggled every cycle.
        tx_q = '{8'h20, 8'h01, 8'h00, 8'h08};
        send_frame(8'h00, 1, 1'b0, 1'b0);

        // Bad checksum (28 instead of 29); err sticky until next header.
        tx_q = '{8'h20, 8'h01, 8'h00, 8'h08};
        send_frame(8'h00, 0, 1'b1, 1'b0);
        repeat (3) idle_cycle();
        check("err_sticky", 32'(err), 1);
        check("hold_sticky", 32'(cpu_hold), 1);
        send_frame({3'($urandom), 5'd2}, 2, 1'b0, 1'b0);

        // Full depth, then upper header bits ignored.
        send_frame(8'h1F, 2, 1'b0, 1'b0);
        send_frame(8'hE1, 0, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++)
            send_frame(8'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);

        send_frame(8'h03, 0, 1'b1, 1'b0);

        // Reset in the middle of the second word.
        send_byte(8'h01, tc);
        w = 32'h0;
        for (int i = 0; i < 6; i++) begin
            tx_q.push_back(8'($urandom));
            send_byte(tx_q[i], tc);
            w = {w[23:0], tx_q[i]};
            if (i == 3) begin
                exp_addr.push_back(5'd0);
                exp_data.push_back(w);
                exp_cyc.push_back(tc + 1);
            end
        end
        tx_q.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_values();
        repeat (5) idle_cycle();
        compare_writes();
        send_frame(8'($urandom), 2, 1'b0, 1'b0);

        check("done_total", mon_done, frames);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
